// File: rtl/wb_lms_pkg.sv
// Shared definitions for the Wishbone host that drives the wb_lms filter slave.
// Holds bus widths, default register addresses and the host FSM encoding.
package wb_lms_pkg;

  localparam int DATA_W = 16;
  localparam int ADDR_W = 4;

  localparam logic [ADDR_W-1:0] ADDR_X_DEF = 4'h0;
  localparam logic [ADDR_W-1:0] ADDR_Y_DEF = 4'h2;
  localparam logic [ADDR_W-1:0] ADDR_E_DEF = 4'h3;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_WR,
    ST_SETTLE,
    ST_RD_Y,
    ST_GAP,
    ST_RD_E,
    ST_DONE
  } host_state_e;

  // A zero settle request still costs one idle cycle so cyc always drops.
  function automatic int settle_cycles(input int s);
    return (s < 1) ? 1 : s;
  endfunction

endpackage

// File: rtl/wb_lms_host_watchdog.sv
// Ack watchdog: counts strobe cycles without ack and pulses timeout_o on the
// TIMEOUT-th one. The count restarts whenever the strobe is low or acked.
module wb_ack_watchdog #(
  parameter int TIMEOUT = 64
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic stb_i,
  input  logic ack_i,
  output logic timeout_o
);

  localparam int CW = $clog2(TIMEOUT + 1);
  localparam logic [CW-1:0] LAST = CW'(TIMEOUT - 1);

  logic [CW-1:0] cnt_q;
  logic [CW-1:0] cnt_d;

  assign cnt_d = cnt_q + 1'b1;

  always_ff @(posedge clk_i) begin
    if (rst_i || !stb_i || ack_i) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign timeout_o = stb_i && !ack_i && (cnt_q == LAST);

endmodule

// File: rtl/wb_lms_host.sv
// Wishbone classic master feeding the wb_lms slave: write a stream sample to X,
// settle, read Y and ERR, and present the pair as one result pulse.
module wb_lms_host
  import wb_lms_pkg::*;
#(
  parameter logic [ADDR_W-1:0] ADDR_X  = ADDR_X_DEF,
  parameter logic [ADDR_W-1:0] ADDR_Y  = ADDR_Y_DEF,
  parameter logic [ADDR_W-1:0] ADDR_E  = ADDR_E_DEF,
  parameter int                SETTLE  = 2,
  parameter int                TIMEOUT = 64
) (
  input  logic              wb_clk_i,
  input  logic              wb_rst_i,
  output logic [ADDR_W-1:0] wb_adr_o,
  output logic [DATA_W-1:0] wb_dat_o,
  input  logic [DATA_W-1:0] wb_dat_i,
  output logic              wb_we_o,
  output logic              wb_stb_o,
  output logic              wb_cyc_o,
  input  logic              wb_ack_i,
  input  logic [DATA_W-1:0] s_data,
  input  logic              s_valid,
  output logic              s_ready,
  output logic [DATA_W-1:0] res_y,
  output logic [DATA_W-1:0] res_err,
  output logic              res_valid,
  output logic              bus_err,
  input  logic              bus_err_clr,
  output logic [DATA_W-1:0] smp_cnt
);

  localparam logic [7:0] SETTLE_LAST = 8'(settle_cycles(SETTLE) - 1);

  host_state_e       state_q;
  logic              cyc_q, stb_q, we_q;
  logic [ADDR_W-1:0] adr_q;
  logic [DATA_W-1:0] dat_q;
  logic [DATA_W-1:0] y_hold_q;
  logic [DATA_W-1:0] res_y_q, res_err_q;
  logic [DATA_W-1:0] smp_cnt_q, smp_cnt_d;
  logic              s_ready_q, res_valid_q, bus_err_q;
  logic [7:0]        settle_q;
  logic              wd_timeout;

  wb_ack_watchdog #(.TIMEOUT(TIMEOUT)) u_wd (
    .clk_i     (wb_clk_i),
    .rst_i     (wb_rst_i),
    .stb_i     (stb_q),
    .ack_i     (wb_ack_i),
    .timeout_o (wd_timeout)
  );

  assign smp_cnt_d = smp_cnt_q + 1'b1;

  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      state_q     <= ST_IDLE;
      cyc_q       <= 1'b0;
      stb_q       <= 1'b0;
      we_q        <= 1'b0;
      adr_q       <= '0;
      dat_q       <= '0;
      y_hold_q    <= '0;
      res_y_q     <= '0;
      res_err_q   <= '0;
      smp_cnt_q   <= '0;
      s_ready_q   <= 1'b0;
      res_valid_q <= 1'b0;
      bus_err_q   <= 1'b0;
      settle_q    <= '0;
    end else begin
      res_valid_q <= 1'b0;
      // Clear first so a timeout on the same edge overrides it.
      if (bus_err_clr) bus_err_q <= 1'b0;
      unique case (state_q)
        ST_IDLE: begin
          s_ready_q <= 1'b1;
          if (s_valid && s_ready_q) begin
            s_ready_q <= 1'b0;
            dat_q     <= s_data;
            adr_q     <= ADDR_X;
            we_q      <= 1'b1;
            cyc_q     <= 1'b1;
            stb_q     <= 1'b1;
            state_q   <= ST_WR;
          end
        end
        ST_WR, ST_RD_Y, ST_RD_E: begin
          if (wb_ack_i) begin
            cyc_q <= 1'b0;
            stb_q <= 1'b0;
            we_q  <= 1'b0;
            if (state_q == ST_WR) begin
              settle_q <= '0;
              state_q  <= ST_SETTLE;
            end else if (state_q == ST_RD_Y) begin
              y_hold_q <= wb_dat_i;
              state_q  <= ST_GAP;
            end else begin
              res_y_q     <= y_hold_q;
              res_err_q   <= wb_dat_i;
              res_valid_q <= 1'b1;
              smp_cnt_q   <= smp_cnt_d;
              state_q     <= ST_DONE;
            end
          end else if (wd_timeout) begin
            // Abandon the sample; results and count stay at the last good values.
            cyc_q     <= 1'b0;
            stb_q     <= 1'b0;
            we_q      <= 1'b0;
            bus_err_q <= 1'b1;
            s_ready_q <= 1'b1;
            state_q   <= ST_IDLE;
          end
        end
        ST_SETTLE: begin
          if (settle_q == SETTLE_LAST) begin
            adr_q   <= ADDR_Y;
            we_q    <= 1'b0;
            cyc_q   <= 1'b1;
            stb_q   <= 1'b1;
            state_q <= ST_RD_Y;
          end else begin
            settle_q <= settle_q + 8'd1;
          end
        end
        ST_GAP: begin
          adr_q   <= ADDR_E;
          cyc_q   <= 1'b1;
          stb_q   <= 1'b1;
          state_q <= ST_RD_E;
        end
        ST_DONE: begin
          s_ready_q <= 1'b1;
          state_q   <= ST_IDLE;
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign wb_adr_o  = adr_q;
  assign wb_dat_o  = dat_q;
  assign wb_we_o   = we_q;
  assign wb_stb_o  = stb_q;
  assign wb_cyc_o  = cyc_q;
  assign s_ready   = s_ready_q;
  assign res_y     = res_y_q;
  assign res_err   = res_err_q;
  assign res_valid = res_valid_q;
  assign bus_err   = bus_err_q;
  assign smp_cnt   = smp_cnt_q;

endmodule
